// File: rtl/arbitro_pkg.sv
// Shared encodings and helpers for the virtual-channel arbiter.
package arbitro_pkg;

  typedef enum logic {
    MODE_STRICT = 1'b0,
    MODE_WRR    = 1'b1
  } arb_mode_e;

  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/arbitro_vc_param_if.sv
// FIFO-head and destination-side bus of the VC arbiter; master is the arbiter.
interface arbitro_vc_param_if #(
  parameter int DATA_W   = 6,
  parameter int NUM_VC   = 2,
  parameter int NUM_DEST = 2
);

  logic [NUM_VC*DATA_W-1:0]   vc_data;
  logic [NUM_VC-1:0]          vc_empty;
  logic [NUM_VC-1:0]          vc_pop;
  logic [NUM_DEST-1:0]        d_pause;
  logic [NUM_DEST*DATA_W-1:0] d_out;
  logic [NUM_DEST-1:0]        d_valid;

  modport master (
    input  vc_data, vc_empty, d_pause,
    output vc_pop, d_out, d_valid
  );

  modport slave (
    output vc_data, vc_empty, d_pause,
    input  vc_pop, d_out, d_valid
  );

endinterface

// File: rtl/arbitro_wrr_sel.sv
// Rotating-priority finder: first eligible VC at or after 'start', wrapping.
module arbitro_wrr_sel
  import arbitro_pkg::*;
#(
  parameter int NUM_VC = 2,
  localparam int VC_W  = clog2(NUM_VC)
) (
  input  logic [NUM_VC-1:0] elig,
  input  logic [VC_W-1:0]   start,
  output logic              found,
  output logic [VC_W-1:0]   idx
);

  // Scan from farthest to nearest so the nearest eligible VC is written last.
  always_comb begin
    found = 1'b0;
    idx   = start;
    for (int k = NUM_VC - 1; k >= 0; k--) begin
      if (elig[(int'(start) + k) % NUM_VC]) begin
        found = 1'b1;
        idx   = VC_W'((int'(start) + k) % NUM_VC);
      end
    end
  end

endmodule

// File: rtl/arbitro_vc_param.sv
// Strict-priority / weighted-round-robin arbiter from VC FIFO heads to destinations.
// Define ARBITRO_WRR_EN to compile in the WRR pointer, credit and mode logic.
module arbitro_vc_param
  import arbitro_pkg::*;
#(
  parameter int DATA_W   = 6,
  parameter int NUM_VC   = 2,
  parameter int NUM_DEST = 2,
  parameter int WEIGHT_W = 3,
  localparam int DEST_W  = clog2(NUM_DEST),
  localparam int VC_W    = clog2(NUM_VC)
) (
  input  logic                       clk,
  input  logic                       reset_L,
  arbitro_vc_param_if.master         bus,
  input  logic                       arb_mode,
  input  logic [NUM_VC*WEIGHT_W-1:0] vc_weight,
  output logic [VC_W-1:0]            grant_id
);

  logic [NUM_VC-1:0]          elig;
  logic [DATA_W-1:0]          head;
  logic                       strict_found, sel_found;
  logic [VC_W-1:0]            strict_idx, sel_idx, grant_q;
  logic [DATA_W-1:0]          gnt_word;
  logic [DEST_W-1:0]          gnt_dest;
  logic [NUM_DEST*DATA_W-1:0] d_out_q;
  logic [NUM_DEST-1:0]        d_valid_q;

  // A pause blocks its destination in the same cycle it is raised.
  always_comb begin
    elig = '0;
    head = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      head    = bus.vc_data[i*DATA_W +: DATA_W];
      elig[i] = !bus.vc_empty[i] && !bus.d_pause[head[DATA_W-1 -: DEST_W]];
    end
  end

  always_comb begin
    strict_found = 1'b0;
    strict_idx   = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        strict_found = 1'b1;
        strict_idx   = VC_W'(i);
      end
    end
  end

`ifdef ARBITRO_WRR_EN
  arb_mode_e             mode_q;
  logic [VC_W-1:0]       ptr_q, ptr_d, next_start, wrr_idx, next_idx;
  logic [WEIGHT_W-1:0]   credit_q, credit_d, base, left;
  logic                  wrr_found, next_found;

  function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [VC_W-1:0] vc);
    logic [WEIGHT_W-1:0] w;
    w = vc_weight[vc*WEIGHT_W +: WEIGHT_W];
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  arbitro_wrr_sel #(.NUM_VC(NUM_VC)) u_sel_grant (
    .elig  (elig),
    .start (ptr_q),
    .found (wrr_found),
    .idx   (wrr_idx)
  );

  assign next_start = (wrr_idx == VC_W'(NUM_VC - 1)) ? '0 : wrr_idx + 1'b1;

  arbitro_wrr_sel #(.NUM_VC(NUM_VC)) u_sel_next (
    .elig  (elig),
    .start (next_start),
    .found (next_found),
    .idx   (next_idx)
  );

  // Zero credit on the pointer VC means "not loaded yet" (after reset).
  always_comb begin
    ptr_d    = ptr_q;
    credit_d = credit_q;
    base     = '0;
    left     = '0;
    if (mode_q == MODE_WRR) begin
      if (wrr_found) begin
        base = (wrr_idx == ptr_q && credit_q != '0) ? credit_q : eff_weight(wrr_idx);
        left = base - 1'b1;
        if (left == '0 && next_found) begin
          ptr_d    = next_idx;
          credit_d = eff_weight(next_idx);
        end else begin
          ptr_d    = wrr_idx;
          credit_d = left;
        end
      end
    end else if (arb_mode == MODE_WRR) begin
      credit_d = eff_weight(ptr_q);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      mode_q   <= MODE_STRICT;
      ptr_q    <= '0;
      credit_q <= '0;
    end else begin
      mode_q   <= arb_mode_e'(arb_mode);
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  assign sel_found = (mode_q == MODE_WRR) ? wrr_found : strict_found;
  assign sel_idx   = (mode_q == MODE_WRR) ? wrr_idx   : strict_idx;
`else
  logic unused_cfg;
  assign unused_cfg = ^{arb_mode, vc_weight};
  assign sel_found  = strict_found;
  assign sel_idx    = strict_idx;
`endif

  assign gnt_word = bus.vc_data[sel_idx*DATA_W +: DATA_W];
  assign gnt_dest = gnt_word[DATA_W-1 -: DEST_W];

  assign bus.vc_pop = (reset_L && sel_found) ? (NUM_VC'(1) << sel_idx) : '0;

  // Only the granted destination slot is rewritten; the others hold.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      d_out_q   <= '0;
      d_valid_q <= '0;
      grant_q   <= '0;
    end else begin
      d_valid_q <= '0;
      if (sel_found) begin
        d_valid_q[gnt_dest]                <= 1'b1;
        d_out_q[gnt_dest*DATA_W +: DATA_W] <= gnt_word;
        grant_q                            <= sel_idx;
      end
    end
  end

  assign bus.d_out   = d_out_q;
  assign bus.d_valid = d_valid_q;
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_arbitro_vc_param.sv
// Randomized bench for arbitro_vc_param with a behavioural arbitration model and directed anchors.
module tb_arbitro_vc_param;

  localparam int DATA_W   = 6;
  localparam int NUM_VC   = 2;
  localparam int NUM_DEST = 2;
  localparam int WEIGHT_W = 3;
  localparam int DEST_W   = 1;
  localparam int VDW      = NUM_VC * DATA_W;
  localparam int WW       = NUM_VC * WEIGHT_W;

  logic          clk;
  logic          reset_L;
  logic          arb_mode;
  logic [WW-1:0] vc_weight;
  logic [0:0]    grant_id;

  int n_cmp;
  int n_fail;

  int                       m_ptr;
  int                       m_credit;
  int                       m_mode;
  logic [NUM_DEST*DATA_W-1:0] exp_dout;
  logic [NUM_DEST-1:0]      exp_dvalid;
  int                       exp_gid;

  arbitro_vc_param_if #(.DATA_W(DATA_W), .NUM_VC(NUM_VC), .NUM_DEST(NUM_DEST)) bus ();

  arbitro_vc_param #(
    .DATA_W(DATA_W), .NUM_VC(NUM_VC), .NUM_DEST(NUM_DEST), .WEIGHT_W(WEIGHT_W)
  ) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .bus       (bus),
    .arb_mode  (arb_mode),
    .vc_weight (vc_weight),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                               input logic [1:0] empty, input logic [1:0] pause);
    @(posedge clk);
    #1;
    bus.vc_data  = {d1, d0};
    bus.vc_empty = empty;
    bus.d_pause  = pause;
  endtask

  function automatic int head_of(int i);
    return int'((bus.vc_data >> (i * DATA_W)) & VDW'((1 << DATA_W) - 1));
  endfunction

  function automatic int dest_of(int word);
    return word >> (DATA_W - DEST_W);
  endfunction

  function automatic int weight_of(int i);
    int w;
    w = int'((vc_weight >> (i * WEIGHT_W)) & WW'((1 << WEIGHT_W) - 1));
    return (w == 0) ? 1 : w;
  endfunction

  // Model: strict picks the lowest eligible VC; WRR scans from the pointer and spends a per-pointer budget.
  always @(negedge clk) begin : compare
    int g;
    int budget;
    int nxt;
    int word;
    int el[NUM_VC];
    if (!reset_L) begin
      checkOutput("reset vc_pop", 32'(bus.vc_pop), 32'd0);
      checkOutput("reset d_valid", 32'(bus.d_valid), 32'd0);
      checkOutput("reset d_out", 32'(bus.d_out), 32'd0);
      checkOutput("reset grant_id", 32'(grant_id), 32'd0);
      m_ptr = 0; m_credit = 0; m_mode = 0;
      exp_dout = '0; exp_dvalid = '0; exp_gid = 0;
    end else begin
      for (int i = 0; i < NUM_VC; i++)
        el[i] = (!bus.vc_empty[i] && !bus.d_pause[dest_of(head_of(i))]) ? 1 : 0;
      g = -1;
      if (m_mode == 1) begin
        for (int k = 0; k < NUM_VC; k++)
          if (g < 0 && el[(m_ptr + k) % NUM_VC] == 1) g = (m_ptr + k) % NUM_VC;
      end else begin
        for (int i = 0; i < NUM_VC; i++)
          if (g < 0 && el[i] == 1) g = i;
      end
      checkOutput("vc_pop", 32'(bus.vc_pop), (g < 0) ? 32'd0 : (32'd1 << g));
      checkOutput("d_valid", 32'(bus.d_valid), 32'(exp_dvalid));
      checkOutput("d_out", 32'(bus.d_out), 32'(exp_dout));
      checkOutput("grant_id", 32'(grant_id), 32'(exp_gid));

      exp_dvalid = '0;
      if (g >= 0) begin
        word = head_of(g);
        exp_dout[dest_of(word)*DATA_W +: DATA_W] = DATA_W'(word);
        exp_dvalid = NUM_DEST'(1 << dest_of(word));
        exp_gid = g;
        if (m_mode == 1) begin
          budget = (g == m_ptr && m_credit > 0) ? m_credit : weight_of(g);
          budget = budget - 1;
          if (budget == 0) begin
            nxt = -1;
            for (int k = 1; k <= NUM_VC; k++)
              if (nxt < 0 && el[(g + k) % NUM_VC] == 1) nxt = (g + k) % NUM_VC;
            m_ptr = nxt;
            m_credit = weight_of(nxt);
          end else begin
            m_ptr = g;
            m_credit = budget;
          end
        end
      end
`ifdef ARBITRO_WRR_EN
      if (m_mode == 0 && arb_mode == 1'b1) m_credit = weight_of(m_ptr);
      m_mode = arb_mode ? 1 : 0;
`endif
    end
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset_L = 1'b0;
    arb_mode = 1'b0;
    vc_weight = '0;
    bus.vc_data = '0;
    bus.vc_empty = 2'b11;
    bus.d_pause = '0;

    #3;
    checkOutput("lit reset vc_pop", 32'(bus.vc_pop), 32'd0);
    checkOutput("lit reset d_valid", 32'(bus.d_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;

    // Both VCs ready, strict: VC0 wins, its word lands on D1.
    applyStimulus(6'b110100, 6'b010110, 2'b00, 2'b00);
    #2 checkOutput("lit strict pop", 32'(bus.vc_pop), 32'b01);
    // D1 paused: VC1 takes the grant toward D0.
    applyStimulus(6'b110100, 6'b010110, 2'b00, 2'b10);
    #2 checkOutput("lit strict d_valid", 32'(bus.d_valid), 32'b10);
    checkOutput("lit strict d_out D1", 32'(bus.d_out[11:6]), 32'b110100);
    checkOutput("lit pause pop", 32'(bus.vc_pop), 32'b10);
    applyStimulus(6'b110100, 6'b010110, 2'b11, 2'b00);
    #2 checkOutput("lit pause d_valid", 32'(bus.d_valid), 32'b01);
    checkOutput("lit pause d_out D0", 32'(bus.d_out[5:0]), 32'b010110);
    checkOutput("lit empty pop", 32'(bus.vc_pop), 32'b00);
    applyStimulus(6'b110100, 6'b010110, 2'b11, 2'b00);
    #2 checkOutput("lit empty d_valid", 32'(bus.d_valid), 32'b00);
    checkOutput("lit empty d_out hold", 32'(bus.d_out), 32'b110100_010110);

`ifdef ARBITRO_WRR_EN
    @(posedge clk);
    #1 reset_L = 1'b0;
    @(posedge clk);
    #1 reset_L = 1'b1;
    arb_mode = 1'b1;
    vc_weight = {3'd1, 3'd2};
    bus.vc_empty = 2'b11;
    begin
      logic [1:0] seq [6];
      seq = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
      for (int i = 0; i < 6; i++) begin
        applyStimulus(6'b000001, 6'b100010, 2'b00, 2'b00);
        #2 checkOutput($sformatf("lit wrr grant %0d", i), 32'(bus.vc_pop), 32'(seq[i]));
      end
    end
    applyStimulus(6'b000001, 6'b100010, 2'b00, 2'b00);
`else
    arb_mode = 1'b1;
    vc_weight = {3'd1, 3'd2};
    applyStimulus(6'b110100, 6'b010110, 2'b00, 2'b00);
    #2 checkOutput("lit no-wrr pop", 32'(bus.vc_pop), 32'b01);
    applyStimulus(6'b110100, 6'b010110, 2'b00, 2'b00);
    #2 checkOutput("lit no-wrr d_valid", 32'(bus.d_valid), 32'b10);
    checkOutput("lit no-wrr d_out D1", 32'(bus.d_out[11:6]), 32'b110100);
`endif
    // Reset in the middle of a busy stream.
    @(posedge clk);
    #1 reset_L = 1'b0;
    #1 checkOutput("lit midreset pop", 32'(bus.vc_pop), 32'd0);
    checkOutput("lit midreset d_valid", 32'(bus.d_valid), 32'd0);
    @(posedge clk);
    #1 reset_L = 1'b1;
    #2 checkOutput("lit post-reset pop", 32'(bus.vc_pop), 32'b01);

    arb_mode = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      bus.vc_data = VDW'($urandom);
      for (int i = 0; i < NUM_VC; i++) bus.vc_empty[i] = ($urandom_range(0, 3) == 0);
      for (int d = 0; d < NUM_DEST; d++) bus.d_pause[d] = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 49) == 0) arb_mode = ~arb_mode;
      if ($urandom_range(0, 99) == 0) vc_weight = WW'($urandom);
      reset_L = ($urandom_range(0, 199) != 0);
    end

    @(posedge clk);
    #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/arbitro_vc_param.md
ARBITRO_VC_PARAM -- requirements
Module: arbitro_vc_param

Interface
- REQ-001 Parameter: DATA_W, 6, word width per VC and per destination.
- REQ-002 Parameter: NUM_VC, 2, number of virtual-channel FIFO heads arbitrated, 2..8.
- REQ-003 Parameter: NUM_DEST, 2, number of destinations, power of two, 2..4; DEST_W = clog2(NUM_DEST).
- REQ-004 Parameter: WEIGHT_W, 3, width of each per-VC weight.
- REQ-005 Port: clk  input  1  single clock, all state on rising edge.
- REQ-006 Port: reset_L  input  1  reset, asynchronous, active-low.
- REQ-007 Port: vc_data  input  NUM_VC*DATA_W  head word of each VC FIFO, VC i at [i*DATA_W +: DATA_W].
- REQ-008 Port: vc_empty  input  NUM_VC  FIFO-empty flag per VC.
- REQ-009 Port: d_pause  input  NUM_DEST  backpressure per destination.
- REQ-010 Port: arb_mode  input  1  0 = strict priority, 1 = weighted round robin.
- REQ-011 Port: vc_weight  input  NUM_VC*WEIGHT_W  WRR weight per VC.
- REQ-012 Port: vc_pop  output  NUM_VC  one-hot pop to the granted FIFO.
- REQ-013 Port: d_out  output  NUM_DEST*DATA_W  registered word per destination.
- REQ-014 Port: d_valid  output  NUM_DEST  d_out qualifier per destination.
- REQ-015 Port: grant_id  output  clog2(NUM_VC)  index of last granted VC, registered.

Function
- REQ-016 Destination of a word SHALL be bits [DATA_W-1 -: DEST_W].
- REQ-017 VC i SHALL be eligible when vc_empty[i]=0 and d_pause[dest(head i)]=0.
- REQ-018 At most one VC SHALL be granted per cycle; vc_pop SHALL be combinational, asserted in the grant cycle, zero when no VC is eligible.
- REQ-019 Granted word SHALL appear on its destination slot of d_out with d_valid high exactly one cycle after pop (latency 1); other d_valid bits low.
- REQ-020 d_out slots not written in a cycle SHALL hold their value; d_valid SHALL be a single-cycle pulse per word.
- REQ-021 Strict mode: lowest-index eligible VC SHALL win.
- REQ-022 WRR mode: pointer VC keeps the grant while eligible and credit>0; each grant decrements credit; on credit reaching 0 or pointer VC ineligible, pointer SHALL advance to next eligible VC (wrap NUM_VC-1 -> 0) and reload its credit from vc_weight in the same cycle.
- REQ-023 Weight 0 SHALL be treated as 1.
- REQ-024 Pause asserted in cycle N SHALL block grants toward that destination in cycle N (no word popped to a paused destination).
- REQ-025 arb_mode change SHALL take effect next cycle; entering WRR reloads pointer VC credit.

Reset
- REQ-026 While reset_L=0: vc_pop=0 (combinationally forced), d_out=0, d_valid=0, grant_id=0, pointer=0, credits=0.
- REQ-027 Reset mid-burst SHALL discard in-flight credit; first grant after release follows REQ-021/022 from VC0.

Configuration
- REQ-028 Macro ARBITRO_WRR_EN: defined -> WRR logic, credits and pointer compiled in; undefined -> strict priority only, arb_mode and vc_weight ignored, no credit registers.

Structure
- REQ-029 Package arbitro_pkg SHALL hold mode encodings (MODE_STRICT, MODE_WRR) and the clog2 function.
- REQ-030 Sub-module arbitro_wrr_sel SHALL implement the rotating-priority eligible-VC finder; instantiated only under ARBITRO_WRR_EN.

Verification (defaults, 2 VC, 2 dest, dest bit 5)
- REQ-031 Strict, VC0=6'b110100, VC1=6'b010110, none empty/paused -> vc_pop=01, next cycle d_out[D1]=6'b110100, d_valid=10.
- REQ-032 Strict, VC0 head to D1, d_pause=10 -> VC1 (6'b010110) granted, next cycle d_valid=01, d_out[D0]=6'b010110.
- REQ-033 WRR, weights VC0=2 VC1=1, both full -> grant sequence 0,0,1,0,0,1.
- REQ-034 Both vc_empty=1 -> vc_pop=00, d_valid=00, d_out holds last values.
- REQ-035 reset_L dropped mid-WRR burst -> vc_pop, d_valid to 0 immediately; after release first grant VC0.
- REQ-036 Build without ARBITRO_WRR_EN, arb_mode=1 -> behaviour identical to REQ-031.
